mcast_grant_arbiter: RTL and testbench
======================================

Name: mcast_grant_arbiter

Overview:
- All-or-nothing output-port arbiter for switch_4port.
- Each input port requests a set of output ports as a target mask (unicast, multicast or broadcast).
- A request is granted only when every output in its mask is free; the granted outputs are locked to that input until it releases them.
- Round-robin priority plus age-based reservation guarantee that wide multicasts are never starved by a stream of narrow unicasts.

Parameters:
- NUM_PORTS, 4, number of input and output ports.
- MAX_WAIT, 8, cycles a request may wait before it becomes urgent.
- WAIT_W, 4, width of the per-input wait counter; must be able to hold MAX_WAIT.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_PORTS  per-input request; held high until grant.
- req_mask  input  NUM_PORTS*NUM_PORTS  per-input target mask; input i uses bits [i*N +: N]; stable while req_valid is high.
- release  input  NUM_PORTS  one-cycle pulse; input i frees every output it holds.
- grant  output  NUM_PORTS  one-cycle pulse per granted input.
- grant_mask  output  NUM_PORTS*NUM_PORTS  per-input effective mask that was locked, valid with grant.
- out_busy  output  NUM_PORTS  output j is locked.
- out_owner  output  NUM_PORTS*2  index of the input holding output j (2 bits each for N=4); 0 when free.
- urgent  output  NUM_PORTS  input i is waiting at or beyond MAX_WAIT.

Behaviour:
- Reset: all per-input states IDLE; grant, grant_mask, out_busy, out_owner and urgent are 0; rr_ptr is 0; wait counters are 0. Reset asserted mid-hold discards every lock.
- Effective mask: req_mask with the requester's own bit cleared (no loopback).
- Empty effective mask: the request is granted on the next edge with grant_mask = 0 and no lock taken, and the input returns to IDLE.
- Per-input FSM:
  - IDLE → req_valid: arbitrated this cycle. Win → HOLD. Lose → WAIT, wait_cnt = 1.
  - WAIT → win → HOLD, wait_cnt = 0. Lose → wait_cnt increments, saturating. req_valid low → IDLE, wait_cnt = 0.
  - HOLD → release → IDLE; that input's busy and owner bits clear on the same edge. While in HOLD, req_valid is ignored.
- Release in IDLE or WAIT is ignored.
- Arbitration is evaluated combinationally each cycle and registered at the edge:
  - Candidates are visited in order rr_ptr, rr_ptr+1, … mod N.
  - A candidate wins if: req_valid is high, it is not in HOLD, and its mask does not intersect out_busy, the masks already won earlier in this cycle's scan, or the reserved mask.
  - Multiple disjoint winners per cycle are allowed.
- Reservation: the first urgent input in rr order has its mask reserved. Any other input whose mask overlaps the reserved mask cannot win until the urgent input is granted.
- Latency: a request arriving on a cycle with all its targets free is granted on the next edge, 1 cycle. grant, grant_mask, out_busy and out_owner update on that same edge.
- Outputs freed by release become available to arbitration on the cycle after the release edge, so the same edge cannot release and re-grant them.
- rr_ptr: after any cycle with at least one grant, rr_ptr = (first winner in scan order + 1) mod N. It is unchanged if there is no grant.
- Zero-mask grants also advance rr_ptr.
- urgent[i] = (state WAIT) && (wait_cnt >= MAX_WAIT).
- Invariant: an output has at most one owner, and a requester either holds all of its masked outputs or none of them.

Test Plan:
- Multicast clash: rr_ptr = 0; inputs 0 and 1 both request mask 4'b1100 on the same cycle → grant = 4'b0001 with grant_mask 1100 and out_busy = 4'b1100. Input 1 waits. After release[0], input 1 is granted exactly 2 edges later.
- Broadcast vs unicast: input 2 mask 1111 (effective 1011) and input 3 mask 0001; input 3 already holds output 0 → input 2 gets no partial grant and out_busy stays 0001 until release[3]. Then grant[2] fires with grant_mask 1011.
- Disjoint parallel grants: input 0 mask 0010 and input 2 mask 1000 on the same cycle → grant = 0101 in a single edge and out_busy = 1010.
- Starvation: input 3 broadcasts while inputs 0 and 1 alternately hold output 2 → urgent[3] rises after 8 waiting cycles, further overlapping grants are blocked, and input 3 is granted within one release of the current holder.
- Loopback/empty: input 1 mask 0010 → grant[1] fires next edge with grant_mask 0000, out_busy is unchanged, and the input returns to IDLE.
- Reset mid-hold: outputs 1 and 2 are held, then rst_n is pulled low asynchronously between edges → out_busy, out_owner and grant read 0 immediately, and the first post-reset request is granted in 1 cycle.

Source files
------------

// File: rtl/mcast_grant_arbiter.sv
`default_nettype none
// ============================================================================
// mcast_grant_arbiter: all-or-nothing multicast output-port arbiter with
// round-robin priority and age-based reservation.      Rev 1.0
// ============================================================================
module mcast_grant_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_WAIT  = 8,
  parameter int WAIT_W    = 4,
  localparam int c_IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           i_req_valid,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] i_req_mask,
  input  logic [NUM_PORTS-1:0]           i_release,
  output logic [NUM_PORTS-1:0]           o_grant,
  output logic [NUM_PORTS*NUM_PORTS-1:0] o_grant_mask,
  output logic [NUM_PORTS-1:0]           o_out_busy,
  output logic [NUM_PORTS*c_IDX_W-1:0]   o_out_owner,
  output logic [NUM_PORTS-1:0]           o_urgent
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef logic [NUM_PORTS-1:0] mask_t;
  typedef logic [c_IDX_W-1:0]   idx_t;

  state_t                          r_state    [NUM_PORTS];
  logic [WAIT_W-1:0]               r_wait_cnt [NUM_PORTS];
  mask_t                           r_held     [NUM_PORTS];
  idx_t                            r_rr_ptr;
  mask_t                           r_grant;
  logic [NUM_PORTS*NUM_PORTS-1:0]  r_grant_mask;
  mask_t                           r_out_busy;
  logic [NUM_PORTS*c_IDX_W-1:0]    r_out_owner;

  mask_t                           w_eff [NUM_PORTS];
  mask_t                           w_urgent;
  mask_t                           w_win;
  mask_t                           w_won;
  mask_t                           w_freed;
  mask_t                           w_busy_nxt;
  mask_t                           w_res_mask;
  logic                            w_res_valid;
  logic                            w_any;
  idx_t                            w_res_idx;
  idx_t                            w_res_scan;
  idx_t                            w_arb_scan;
  idx_t                            w_first;
  logic [NUM_PORTS*NUM_PORTS-1:0]  w_gmask_nxt;
  logic [NUM_PORTS*c_IDX_W-1:0]    w_owner_nxt;

  function automatic idx_t ptr_add(input idx_t base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return idx_t'(s);
  endfunction

  // Own bit is stripped so a port never targets itself.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign w_eff[gi]    = i_req_mask[gi*NUM_PORTS +: NUM_PORTS] & ~(mask_t'(1) << gi);
    assign w_urgent[gi] = (r_state[gi] == S_WAIT) && (r_wait_cnt[gi] >= WAIT_W'(MAX_WAIT));
  end

  always_comb begin
    w_res_valid = 1'b0;
    w_res_idx   = '0;
    w_res_mask  = '0;
    w_res_scan  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_res_scan = ptr_add(r_rr_ptr, k);
      if (!w_res_valid && w_urgent[w_res_scan]) begin
        w_res_valid = 1'b1;
        w_res_idx   = w_res_scan;
        w_res_mask  = w_eff[w_res_scan];
      end
    end
  end

  // Greedy scan from rr_ptr; each winner claims its whole mask for later candidates.
  always_comb begin
    w_win      = '0;
    w_won      = '0;
    w_any      = 1'b0;
    w_first    = '0;
    w_arb_scan = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_arb_scan = ptr_add(r_rr_ptr, k);
      if (i_req_valid[w_arb_scan] && (r_state[w_arb_scan] != S_HOLD)
          && ((w_eff[w_arb_scan] & (r_out_busy | w_won)) == '0)
          && (!w_res_valid || (w_arb_scan == w_res_idx)
              || ((w_eff[w_arb_scan] & w_res_mask) == '0))) begin
        w_win[w_arb_scan] = 1'b1;
        w_won             = w_won | w_eff[w_arb_scan];
        if (!w_any) begin
          w_any   = 1'b1;
          w_first = w_arb_scan;
        end
      end
    end
  end

  always_comb begin
    w_freed     = '0;
    w_gmask_nxt = '0;
    w_owner_nxt = r_out_owner;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if ((r_state[i] == S_HOLD) && i_release[i]) w_freed = w_freed | r_held[i];
      if (w_win[i]) w_gmask_nxt[i*NUM_PORTS +: NUM_PORTS] = w_eff[i];
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (w_freed[j]) w_owner_nxt[j*c_IDX_W +: c_IDX_W] = '0;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (w_win[i] && w_eff[i][j]) w_owner_nxt[j*c_IDX_W +: c_IDX_W] = idx_t'(i);
      end
    end
    w_busy_nxt = (r_out_busy & ~w_freed) | w_won;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_state[i]    <= S_IDLE;
        r_wait_cnt[i] <= '0;
        r_held[i]     <= '0;
      end
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_grant_mask <= '0;
      r_out_busy   <= '0;
      r_out_owner  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (i_req_valid[i]) begin
              if (w_win[i]) begin
                r_state[i] <= (w_eff[i] != '0) ? S_HOLD : S_IDLE;
                r_held[i]  <= w_eff[i];
              end else begin
                r_state[i]    <= S_WAIT;
                r_wait_cnt[i] <= WAIT_W'(1);
              end
            end
          end
          S_WAIT: begin
            if (!i_req_valid[i]) begin
              r_state[i]    <= S_IDLE;
              r_wait_cnt[i] <= '0;
            end else if (w_win[i]) begin
              r_state[i]    <= (w_eff[i] != '0) ? S_HOLD : S_IDLE;
              r_held[i]     <= w_eff[i];
              r_wait_cnt[i] <= '0;
            end else if (r_wait_cnt[i] != '1) begin
              r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
            end
          end
          S_HOLD: begin
            if (i_release[i]) begin
              r_state[i] <= S_IDLE;
              r_held[i]  <= '0;
            end
          end
          default: begin
            r_state[i]    <= S_IDLE;
            r_wait_cnt[i] <= '0;
            r_held[i]     <= '0;
          end
        endcase
      end
      r_grant      <= w_win;
      r_grant_mask <= w_gmask_nxt;
      r_out_busy   <= w_busy_nxt;
      r_out_owner  <= w_owner_nxt;
      if (w_any) r_rr_ptr <= ptr_add(w_first, 1);
    end
  end

  assign o_grant      = r_grant;
  assign o_grant_mask = r_grant_mask;
  assign o_out_busy   = r_out_busy;
  assign o_out_owner  = r_out_owner;
  assign o_urgent     = w_urgent;

endmodule
`default_nettype wire

// File: tb/tb_mcast_grant_arbiter.sv
`default_nettype none
// Bench for mcast_grant_arbiter: directed scenarios, then random traffic
// compared cycle by cycle against an ownership-table reference model.
module tb_mcast_grant_arbiter;
  localparam int N       = 4;
  localparam int MW      = 8;
  localparam int WW      = 4;
  localparam int AGE_MAX = (1 << WW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*N-1:0] req_mask = '0;
  logic [N-1:0]   rel = '0;
  logic [N-1:0]   grant, busy, urgent;
  logic [N*N-1:0] gmask;
  logic [N*2-1:0] owner;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns each output, who is waiting and for how long.
  int  m_owner [N];
  bit  m_inhold[N];
  bit  m_wait  [N];
  int  m_age   [N];
  int  m_rr;
  logic [N-1:0]   e_grant, e_busy, e_urgent;
  logic [N*N-1:0] e_gmask;
  logic [N*2-1:0] e_owner;
  logic [N-1:0]   rmask;

  mcast_grant_arbiter #(.NUM_PORTS(N), .MAX_WAIT(MW), .WAIT_W(WW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .i_req_mask   (req_mask),
    .i_release    (rel),
    .o_grant      (grant),
    .o_grant_mask (gmask),
    .o_out_busy   (busy),
    .o_out_owner  (owner),
    .o_urgent     (urgent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_owner[p] = -1; m_inhold[p] = 0; m_wait[p] = 0; m_age[p] = 0;
    end
    m_rr = 0;
    e_grant = '0; e_busy = '0; e_urgent = '0; e_gmask = '0; e_owner = '0;
  endtask

  task automatic model_eval();
    int eff [N];
    bit win [N];
    int resv, resm, taken, first, i;
    for (int p = 0; p < N; p++) begin
      eff[p] = int'(req_mask[p*N +: N]) & ~(1 << p);
      win[p] = 0;
    end
    resv = -1; resm = 0;
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (resv < 0 && m_wait[i] && m_age[i] >= MW) begin resv = i; resm = eff[i]; end
    end
    taken = 0;
    for (int j = 0; j < N; j++) if (m_owner[j] >= 0) taken |= (1 << j);
    first = -1;
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (req_valid[i] && !m_inhold[i] && (eff[i] & taken) == 0
          && (resv < 0 || resv == i || (eff[i] & resm) == 0)) begin
        win[i] = 1;
        taken |= eff[i];
        if (first < 0) first = i;
      end
    end
    for (int p = 0; p < N; p++) begin
      if (win[p] || !req_valid[p]) begin
        m_wait[p] = 0; m_age[p] = 0;
      end else if (!m_inhold[p]) begin
        if (m_wait[p]) m_age[p] = (m_age[p] < AGE_MAX) ? m_age[p] + 1 : AGE_MAX;
        else begin m_wait[p] = 1; m_age[p] = 1; end
      end
    end
    for (int p = 0; p < N; p++) begin
      if (m_inhold[p] && rel[p]) begin
        for (int j = 0; j < N; j++) if (m_owner[j] == p) m_owner[j] = -1;
        m_inhold[p] = 0;
      end
    end
    e_gmask = '0;
    for (int p = 0; p < N; p++) begin
      e_grant[p] = win[p];
      if (win[p]) begin
        for (int j = 0; j < N; j++) if (((eff[p] >> j) & 1) != 0) m_owner[j] = p;
        m_inhold[p] = (eff[p] != 0);
        e_gmask[p*N +: N] = eff[p][N-1:0];
      end
    end
    if (first >= 0) m_rr = (first + 1) % N;
    for (int j = 0; j < N; j++) begin
      e_busy[j] = (m_owner[j] >= 0);
      e_owner[j*2 +: 2] = (m_owner[j] >= 0) ? m_owner[j][1:0] : 2'd0;
    end
    for (int p = 0; p < N; p++) e_urgent[p] = m_wait[p] && (m_age[p] >= MW);
  endtask

  task automatic check_all();
    chk("model_grant",  grant,  e_grant);
    chk("model_gmask",  gmask,  e_gmask);
    chk("model_busy",   busy,   e_busy);
    chk("model_owner",  owner,  e_owner);
    chk("model_urgent", urgent, e_urgent);
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_mask = '0; rel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("reset_grant", grant, 0);
    chk("reset_gmask", gmask, 0);
    chk("reset_busy", busy, 0);
    chk("reset_owner", owner, 0);
    chk("reset_urgent", urgent, 0);

    // Multicast clash on outputs 2,3
    req_mask[3:0] = 4'b1100; req_mask[7:4] = 4'b1100; req_valid = 4'b0011;
    step();
    chk("clash_grant", grant, 4'b0001);
    chk("clash_gmask", gmask, 16'h000C);
    chk("clash_busy", busy, 4'b1100);
    req_valid = 4'b0010;
    step(); step();
    rel = 4'b0001; step(); rel = '0;
    chk("clash_rel_busy", busy, 4'b0000);
    chk("clash_rel_grant", grant, 4'b0000);
    step();
    chk("clash_late_grant", grant, 4'b0010);
    chk("clash_late_gmask", gmask, 16'h00C0);
    chk("clash_late_owner", owner, 8'h50);
    req_valid = '0;

    // Broadcast waits behind a unicast holder, no partial grant
    do_reset();
    req_mask[15:12] = 4'b0001; req_valid = 4'b1000;
    step();
    chk("bcast_uni_grant", grant, 4'b1000);
    chk("bcast_uni_owner", owner, 8'h03);
    req_valid = '0;
    req_mask[11:8] = 4'b1111; req_valid = 4'b0100;
    step();
    chk("bcast_wait_grant", grant, 4'b0000);
    chk("bcast_wait_busy", busy, 4'b0001);
    step();
    chk("bcast_wait_busy2", busy, 4'b0001);
    rel = 4'b1000; step(); rel = '0;
    chk("bcast_rel_busy", busy, 4'b0000);
    step();
    chk("bcast_grant", grant, 4'b0100);
    chk("bcast_gmask", gmask, 16'h0B00);
    chk("bcast_busy", busy, 4'b1011);
    chk("bcast_owner", owner, 8'h8A);
    req_valid = '0;

    // Disjoint parallel grants, then loopback-only request
    do_reset();
    req_mask[3:0] = 4'b0010; req_mask[11:8] = 4'b1000; req_valid = 4'b0101;
    step();
    chk("disj_grant", grant, 4'b0101);
    chk("disj_gmask", gmask, 16'h0802);
    chk("disj_busy", busy, 4'b1010);
    chk("disj_owner", owner, 8'h80);
    req_valid = '0;
    req_mask[7:4] = 4'b0010; req_valid = 4'b0010;
    step();
    chk("loop_grant", grant, 4'b0010);
    chk("loop_gmask", gmask, 16'h0000);
    chk("loop_busy", busy, 4'b1010);
    req_valid = '0;
    step();
    chk("loop_idle_grant", grant, 4'b0000);
    req_mask[7:4] = 4'b0001; req_valid = 4'b0010;
    step();
    chk("loop_regrant", grant, 4'b0010);
    chk("loop_regrant_busy", busy, 4'b1011);
    req_valid = '0;

    // Starvation: input 3 broadcasts while 0 and 1 trade output 2
    do_reset();
    req_mask[3:0] = 4'b0100; req_mask[11:8] = 4'b0010; req_valid = 4'b0101;
    step();
    chk("starve_setup", grant, 4'b0101);
    req_valid = '0;
    req_mask[7:4] = 4'b0100; req_mask[15:12] = 4'b1111; req_valid = 4'b1010;
    for (int c = 0; c < 20; c++) begin
      rel = '0;
      if (c % 3 == 2 && m_owner[2] >= 0) rel[m_owner[2]] = 1'b1;
      if (c == 11) rel[2] = 1'b1;
      for (int p = 0; p < 2; p++)
        if (!m_inhold[p] && !req_valid[p] && !rel[p]) req_valid[p] = 1'b1;
      step();
      req_valid &= ~e_grant;
      if (c < 15) chk("starve_urgent", urgent[3], (c >= 7 && c < 12));
      if (c >= 9 && c <= 11) chk("starve_reserved", grant, 4'b0000);
      if (c == 12) begin
        chk("starve_grant", grant, 4'b1000);
        chk("starve_gmask", gmask, 16'h7000);
      end
    end
    rel = '0;

    // Asynchronous reset while outputs 1,2 are held
    do_reset();
    req_mask[3:0] = 4'b0110; req_valid = 4'b0001;
    step();
    chk("rst_hold_busy", busy, 4'b0110);
    req_valid = '0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_owner", owner, 0);
    chk("rst_async_grant", grant, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_mask[11:8] = 4'b0001; req_valid = 4'b0100;
    step();
    chk("rst_first_grant", grant, 4'b0100);
    chk("rst_first_busy", busy, 4'b0001);
    req_valid = '0;

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rel = '0;
      for (int p = 0; p < N; p++) begin
        if (m_inhold[p]) begin
          if ($urandom_range(0, 3) == 0) rel[p] = 1'b1;
        end else if (!req_valid[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 3))
              0:       rmask = 4'b0001 << $urandom_range(0, 3);
              1:       rmask = 4'b1111;
              2:       rmask = 4'($urandom);
              default: rmask = 4'b0001 << p;
            endcase
            req_mask[p*N +: N] = rmask;
            req_valid[p] = 1'b1;
          end else if ($urandom_range(0, 15) == 0) begin
            rel[p] = 1'b1;
          end
        end
      end
      step();
      req_valid &= ~e_grant;
    end
    rel = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
